cd_reply_route_ctrl: RTL and testbench



---
 rtl/cd_mesh_pkg.sv | 22 ++
 rtl/cd_reply_route_ctrl_if.sv | 28 ++
 rtl/cd_reply_route_ctrl_chan_fsm.sv | 57 +++++
 rtl/cd_reply_route_ctrl.sv | 113 +++++++++++
 tb/tb_cd_reply_route_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cd_mesh_pkg.sv
// -----------------------------------------------------------------------------
// cd_mesh_pkg
// Shared definitions for the local converge-diverge mesh blocks:
//   - flit field positions (destination index, head and tail markers)
//   - dest2oh: 2-bit router index to one-hot route select
//   - per-channel FSM state encoding
// -----------------------------------------------------------------------------
package cd_mesh_pkg;

  localparam int DEST_LSB = 48;
  localparam int HEAD_BIT = 63;
  localparam int TAIL_BIT = 62;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Index 0 selects 0001, index 3 selects 1000.
  function automatic logic [3:0] dest2oh(input logic [1:0] dest);
    return 4'b0001 << dest;
  endfunction

endpackage

// File: rtl/cd_reply_route_ctrl_if.sv
// -----------------------------------------------------------------------------
// cd_reply_route_ctrl_if
// Reply-channel bundle between the crossbar and the route controller.
//   cv_si_r  : per-channel flit valid
//   cv_ri_r  : per-channel ready as driven by the crossbar
//   cv_di_r  : two flits, channel i in [DATA_W*(i+1)-1 : DATA_W*i]
//   sel_cv0/1: one-hot route per channel, 0000 = stall
// Modports: master = crossbar side, slave = route controller side.
// -----------------------------------------------------------------------------
interface cd_reply_route_ctrl_if #(
  parameter int DATA_W = 64
);
  logic [1:0]          cv_si_r;
  logic [1:0]          cv_ri_r;
  logic [2*DATA_W-1:0] cv_di_r;
  logic [3:0]          sel_cv0;
  logic [3:0]          sel_cv1;

  modport master (
    output cv_si_r, cv_ri_r, cv_di_r,
    input  sel_cv0, sel_cv1
  );

  modport slave (
    input  cv_si_r, cv_ri_r, cv_di_r,
    output sel_cv0, sel_cv1
  );
endinterface

// File: rtl/cd_reply_route_ctrl_chan_fsm.sv
// -----------------------------------------------------------------------------
// cd_reply_chan_fsm
// Per-channel packet lock. Captures the granted route on the transfer of an
// opening flit without tail and holds it until the tail transfers.
//   clk, reset : clock, synchronous active-high reset
//   xfer       : a flit on this channel transferred this cycle
//   head, tail : marker bits of the current flit
//   sel        : route granted to this channel this cycle
//   busy       : channel is locked mid-packet (registered)
//   lock       : locked route, 0000 when idle
//   hdr_err    : a non-head flit transferred while idle (one-cycle pulse)
// -----------------------------------------------------------------------------
module cd_reply_chan_fsm
  import cd_mesh_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       xfer,
  input  logic       head,
  input  logic       tail,
  input  logic [3:0] sel,
  output logic       busy,
  output logic [3:0] lock,
  output logic       hdr_err
);

  logic [0:0] state;

  assign busy    = (state == BUSY);
  assign hdr_err = xfer && (state == IDLE) && !head;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lock  <= 4'b0000;
    end else if (xfer) begin
      case (state)
        IDLE: begin
          // A headless flit is still routed as a head; only tail decides.
          if (!tail) begin
            state <= BUSY;
            lock  <= sel;
          end
        end
        default: begin
          if (tail) begin
            state <= IDLE;
            lock  <= 4'b0000;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cd_reply_route_ctrl.sv
// -----------------------------------------------------------------------------
// cd_reply_route_ctrl
// Reply-path route controller for the 4x2 converge-diverge crossbar. Decodes
// head-flit destinations on both converged reply channels into one-hot
// selects, locks routes for multi-flit packets and resolves same-destination
// head conflicts round-robin. A stalled channel sees sel = 0000.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : reply-channel valid/ready/flits in, sel_cv0/sel_cv1 out
//   busy[1:0]    : channel locked mid-packet
//   proto_err    : sticky, a non-head flit arrived on an idle channel
//   conflict_cnt : saturating count of stalled valid channel-cycles, present
//                  only when CD_REPLY_ROUTE_CTRL_STATS_EN is defined
// -----------------------------------------------------------------------------
module cd_reply_route_ctrl
  import cd_mesh_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEST_LSB = cd_mesh_pkg::DEST_LSB,
  parameter int HEAD_BIT = cd_mesh_pkg::HEAD_BIT,
  parameter int TAIL_BIT = cd_mesh_pkg::TAIL_BIT,
  parameter int STAT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cd_reply_route_ctrl_if.slave bus,
  output logic [1:0]           busy,
  output logic                 proto_err
`ifdef CD_REPLY_ROUTE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]    conflict_cnt
`endif
);

  logic [1:0]      vld, head, tail, xfer, hdr_err;
  logic [1:0][3:0] dec, lock, cand, sel;
  logic            prio;
  logic            conflict;

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic [DATA_W-1:0] flit;
    assign flit    = bus.cv_di_r[DATA_W*i +: DATA_W];
    assign vld[i]  = bus.cv_si_r[i];
    assign dec[i]  = dest2oh(flit[DEST_LSB +: 2]);
    assign head[i] = flit[HEAD_BIT];
    assign tail[i] = flit[TAIL_BIT];
    // A stalled channel cannot transfer even if ready is seen high.
    assign xfer[i] = vld[i] && bus.cv_ri_r[i] && (sel[i] != 4'b0000);

    cd_reply_chan_fsm u_fsm (
      .clk     (clk),
      .reset   (reset),
      .xfer    (xfer[i]),
      .head    (head[i]),
      .tail    (tail[i]),
      .sel     (sel[i]),
      .busy    (busy[i]),
      .lock    (lock[i]),
      .hdr_err (hdr_err[i])
    );
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    cand     = '0;
    sel      = '0;
    conflict = !busy[0] && !busy[1] && vld[0] && vld[1] && (dec[0] == dec[1]);
    for (int i = 0; i < 2; i++) begin
      cand[i] = busy[i] ? lock[i] : (vld[i] ? dec[i] : 4'b0000);
      sel[i]  = cand[i];
      if (!busy[i]) begin
        // A locked route on the other channel always beats a new head.
        if (busy[1-i] && (cand[i] == lock[1-i])) begin
          sel[i] = 4'b0000;
        end else if (conflict && (int'(prio) != i)) begin
          sel[i] = 4'b0000;
        end
      end
    end
  end

  assign bus.sel_cv0 = sel[0];
  assign bus.sel_cv1 = sel[1];

  // prio moves only once the winner's flit is accepted, so the grant stays
  // stable while the output is back-pressured.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (conflict && xfer[prio]) prio <= ~prio;
      if (|hdr_err)               proto_err <= 1'b1;
    end
  end

`ifdef CD_REPLY_ROUTE_CTRL_STATS_EN
  logic [1:0]      stall;
  logic [STAT_W:0] cnt_sum;

  assign stall[0] = vld[0] && (sel[0] == 4'b0000);
  assign stall[1] = vld[1] && (sel[1] == 4'b0000);
  assign cnt_sum  = {1'b0, conflict_cnt} + (STAT_W+1)'(stall[0])
                  + (STAT_W+1)'(stall[1]);

  always_ff @(posedge clk) begin
    if (reset)                conflict_cnt <= '0;
    else if (cnt_sum[STAT_W]) conflict_cnt <= '1;
    else                      conflict_cnt <= cnt_sum[STAT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_cd_reply_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cd_reply_route_ctrl
// Self-checking bench for cd_reply_route_ctrl. Directed scenarios use fixed
// expectations; the random scenario compares against a packet-level model
// that tracks per-channel "in packet" flags and destination indices.
// Inputs change on the falling edge; the bench's crossbar stand-in only
// raises ready for channels the model expects to be routed.
// -----------------------------------------------------------------------------
module tb_cd_reply_route_ctrl;
  import cd_mesh_pkg::*;

  localparam int DATA_W  = 64;
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  busy;
  logic        proto_err;
  logic [15:0] conflict_cnt;

  cd_reply_route_ctrl_if #(.DATA_W(DATA_W)) bus ();

  cd_reply_route_ctrl #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .proto_err    (proto_err)
`ifdef CD_REPLY_ROUTE_CTRL_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

`ifndef CD_REPLY_ROUTE_CTRL_STATS_EN
  assign conflict_cnt = 16'd0;
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Currently driven stimulus.
  bit       v[2], h[2], t[2], r[2];
  bit [1:0] d[2];
  logic [3:0] exp_sel[2];

  // Packet-level reference state.
  bit m_busy[2];
  int m_dest[2];
  int m_prio;
  bit m_perr;
  int m_cnt;

  function automatic logic [3:0] oh(input int idx);
    logic [3:0] one = 4'b0001;
    return one << idx;
  endfunction

  // Drive one cycle of stimulus at the falling edge and predict the routes.
  task automatic apply(input bit v0, h0, t0, input bit [1:0] d0, input bit r0,
                       input bit v1, h1, t1, input bit [1:0] d1, input bit r1);
    logic [DATA_W-1:0] f[2];
    bit rq[2];
    bit same_head;
    @(negedge clk);
    v[0] = v0; h[0] = h0; t[0] = t0; d[0] = d0; rq[0] = r0;
    v[1] = v1; h[1] = h1; t[1] = t1; d[1] = d1; rq[1] = r1;
    same_head = !m_busy[0] && !m_busy[1] && v[0] && v[1] && (d[0] == d[1]);
    for (int i = 0; i < 2; i++) begin
      f[i] = {$urandom, $urandom};
      f[i][HEAD_BIT] = h[i];
      f[i][TAIL_BIT] = t[i];
      f[i][DEST_LSB +: 2] = d[i];
      if (m_busy[i])                                   exp_sel[i] = oh(m_dest[i]);
      else if (!v[i])                                  exp_sel[i] = 4'b0000;
      else if (m_busy[1-i] && m_dest[1-i] == int'(d[i])) exp_sel[i] = 4'b0000;
      else if (same_head && i != m_prio)               exp_sel[i] = 4'b0000;
      else                                             exp_sel[i] = oh(int'(d[i]));
      r[i] = rq[i] && (exp_sel[i] != 4'b0000);
    end
    bus.cv_si_r = {v[1], v[0]};
    bus.cv_ri_r = {r[1], r[0]};
    bus.cv_di_r = {f[1], f[0]};
    #1;
  endtask

  // Clock edge: advance the reference model with the transfers that happened.
  task automatic tick();
    bit same_head;
    bit x[2];
    @(posedge clk);
    same_head = !m_busy[0] && !m_busy[1] && v[0] && v[1] && (d[0] == d[1]);
    for (int i = 0; i < 2; i++) x[i] = v[i] && r[i];
    for (int i = 0; i < 2; i++)
      if (v[i] && exp_sel[i] == 4'b0000 && m_cnt < CNT_MAX) m_cnt++;
    if (same_head && x[m_prio]) m_prio = 1 - m_prio;
    for (int i = 0; i < 2; i++) begin
      if (x[i]) begin
        if (!m_busy[i]) begin
          if (!h[i]) m_perr = 1'b1;
          if (!t[i]) begin
            m_busy[i] = 1'b1;
            m_dest[i] = int'(d[i]);
          end
        end else if (t[i]) begin
          m_busy[i] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.cv_si_r = 2'b00;
    bus.cv_ri_r = 2'b00;
    v[0] = 1'b0; v[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_busy[0] = 1'b0; m_busy[1] = 1'b0;
    m_prio = 0; m_perr = 1'b0; m_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (busy !== 2'b00) begin n_err++; $display("FAIL reset_busy got=%b want=00", busy); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b want=0", proto_err); end
    n_cmp++; if (bus.sel_cv0 !== 4'b0000 || bus.sel_cv1 !== 4'b0000) begin
      n_err++; $display("FAIL reset_sel got=%b/%b want=0000/0000", bus.sel_cv0, bus.sel_cv1); end
`ifdef CD_REPLY_ROUTE_CTRL_STATS_EN
    n_cmp++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", conflict_cnt); end
`endif
  endtask

  task automatic test_single_flit();
    apply(1, 1, 1, 2'd2, 1, 1, 1, 1, 2'd1, 1);
    n_cmp++; if (bus.sel_cv0 !== 4'b0100) begin n_err++; $display("FAIL single_sel0 got=%b want=0100", bus.sel_cv0); end
    n_cmp++; if (bus.sel_cv1 !== 4'b0010) begin n_err++; $display("FAIL single_sel1 got=%b want=0010", bus.sel_cv1); end
    tick();
    n_cmp++; if (busy !== 2'b00) begin n_err++; $display("FAIL single_busy got=%b want=00", busy); end
  endtask

  task automatic test_multi_flit();
    bit rdy_pat[6] = '{0, 1, 0, 1, 0, 1};
    int idx = 0;
    for (int c = 0; c < 6; c++) begin
      apply(1, idx == 0, idx == 2, (idx == 0) ? 2'd3 : 2'($urandom), rdy_pat[c],
            0, 0, 0, 2'd0, 0);
      n_cmp++; if (bus.sel_cv0 !== 4'b1000) begin
        n_err++; $display("FAIL multi_sel0 cyc=%0d got=%b want=1000", c, bus.sel_cv0); end
      tick();
      if (rdy_pat[c]) idx++;
      n_cmp++; if (busy[0] !== (idx >= 1 && idx <= 2)) begin
        n_err++; $display("FAIL multi_busy cyc=%0d got=%b want=%b", c, busy[0], (idx >= 1 && idx <= 2)); end
    end
    apply(0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
    n_cmp++; if (bus.sel_cv0 !== 4'b0000) begin n_err++; $display("FAIL multi_lock_clear got=%b want=0000", bus.sel_cv0); end
  endtask

  task automatic test_head_conflict();
    logic [3:0] w0[4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
    logic [3:0] w1[4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
    bit rr[4] = '{0, 1, 1, 1};
    for (int c = 0; c < 4; c++) begin
      apply(1, 1, 1, 2'd0, rr[c], 1, 1, 1, 2'd0, 1);
      n_cmp++; if (bus.sel_cv0 !== w0[c] || bus.sel_cv1 !== w1[c]) begin
        n_err++; $display("FAIL head_conflict cyc=%0d got=%b/%b want=%b/%b", c, bus.sel_cv0, bus.sel_cv1, w0[c], w1[c]); end
      tick();
    end
  endtask

  task automatic test_locked_conflict();
    bit ct[3] = '{0, 1, 1};
    bit cr[3] = '{1, 0, 1};
    apply(0, 0, 0, 2'd0, 0, 1, 1, 0, 2'd2, 1);
    n_cmp++; if (bus.sel_cv1 !== 4'b0100) begin n_err++; $display("FAIL locked_head1 got=%b want=0100", bus.sel_cv1); end
    tick();
    n_cmp++; if (busy !== 2'b10) begin n_err++; $display("FAIL locked_busy got=%b want=10", busy); end
    for (int c = 0; c < 3; c++) begin
      apply(1, 1, 1, 2'd2, 1, 1, 0, ct[c], 2'($urandom), cr[c]);
      n_cmp++; if (bus.sel_cv0 !== 4'b0000 || bus.sel_cv1 !== 4'b0100) begin
        n_err++; $display("FAIL locked_stall cyc=%0d got=%b/%b want=0000/0100", c, bus.sel_cv0, bus.sel_cv1); end
      tick();
    end
    apply(1, 1, 1, 2'd2, 1, 0, 0, 0, 2'd0, 0);
    n_cmp++; if (bus.sel_cv0 !== 4'b0100) begin n_err++; $display("FAIL locked_release got=%b want=0100", bus.sel_cv0); end
    tick();
`ifdef CD_REPLY_ROUTE_CTRL_STATS_EN
    n_cmp++; if (conflict_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL locked_cnt got=%0d want=%0d", conflict_cnt, m_cnt); end
`endif
  endtask

  task automatic test_proto_err();
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL perr_before got=%b want=0", proto_err); end
    apply(0, 0, 0, 2'd0, 0, 1, 0, 1, 2'd1, 1);
    n_cmp++; if (bus.sel_cv1 !== 4'b0010) begin n_err++; $display("FAIL perr_sel1 got=%b want=0010", bus.sel_cv1); end
    tick();
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky cyc=%0d got=%b want=1", c, proto_err); end
      apply(1, 1, 1, 2'($urandom), 1, 0, 0, 0, 2'd0, 0);
      tick();
    end
  endtask

  task automatic test_reset_mid_packet();
    apply(1, 1, 1, 2'd1, 1, 1, 1, 1, 2'd1, 1);  // ch0 wins, prio moves to ch1
    tick();
    apply(1, 1, 0, 2'd3, 1, 0, 0, 0, 2'd0, 0);
    tick();
    n_cmp++; if (busy !== 2'b01) begin n_err++; $display("FAIL midrst_busy_pre got=%b want=01", busy); end
    do_reset();
    n_cmp++; if (busy !== 2'b00 || proto_err !== 1'b0) begin
      n_err++; $display("FAIL midrst_state got=%b/%b want=00/0", busy, proto_err); end
    n_cmp++; if (bus.sel_cv0 !== 4'b0000 || bus.sel_cv1 !== 4'b0000) begin
      n_err++; $display("FAIL midrst_sel got=%b/%b want=0000/0000", bus.sel_cv0, bus.sel_cv1); end
    apply(1, 1, 1, 2'd2, 1, 1, 1, 1, 2'd2, 1);
    n_cmp++; if (bus.sel_cv0 !== 4'b0100 || bus.sel_cv1 !== 4'b0000) begin
      n_err++; $display("FAIL midrst_prio got=%b/%b want=0100/0000", bus.sel_cv0, bus.sel_cv1); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
            2'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
            2'($urandom), $urandom_range(0, 3) != 0);
      n_cmp++; if (bus.sel_cv0 !== exp_sel[0] || bus.sel_cv1 !== exp_sel[1]) begin
        n_err++; $display("FAIL rand_sel cyc=%0d got=%b/%b want=%b/%b", c, bus.sel_cv0, bus.sel_cv1, exp_sel[0], exp_sel[1]); end
      n_cmp++; if (busy === 2'b11 && bus.sel_cv0 === bus.sel_cv1) begin
        n_err++; $display("FAIL rand_same_lock cyc=%0d got=%b/%b want=distinct", c, bus.sel_cv0, bus.sel_cv1); end
      tick();
      n_cmp++; if (busy !== {m_busy[1], m_busy[0]} || proto_err !== m_perr) begin
        n_err++; $display("FAIL rand_state cyc=%0d got=%b/%b want=%b%b/%b", c, busy, proto_err, m_busy[1], m_busy[0], m_perr); end
`ifdef CD_REPLY_ROUTE_CTRL_STATS_EN
      n_cmp++; if (conflict_cnt !== 16'(m_cnt)) begin
        n_err++; $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", c, conflict_cnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cv_si_r = 2'b00;
    bus.cv_ri_r = 2'b00;
    bus.cv_di_r = '0;
    test_reset();
    test_single_flit();
    test_multi_flit();
    test_head_conflict();
    test_locked_conflict();
    test_proto_err();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
